kb_code_ascii_converter: RTL and testbench
==========================================

// Module: kb_code_ascii_converter
// PURPOSE
//   Translates a PS/2 scan-code-set-2 make code into 8-bit ASCII.
//   Applies shift and caps_lock modifiers.
//   Sits between the PS/2 deserializer (keyboard_controller) and downstream ASCII consumers.
//   Output is registered on clk. Unmapped codes yield 0x00.
// PARAMETERS
//   UNMAPPED  8'h00  ASCII value driven for any scan code not in the table
// PORTS
//   clk        in   1  system clock; all state updates on rising edge
//   reset      in   1  synchronous, active-high reset
//   kb_code    in   8  set-2 make code (last key released, from deserializer)
//   caps_lock  in   1  level; 1 = caps lock engaged
//   shift      in   1  level; 1 = either shift key held
//   ascii      out  8  translated ASCII character, registered
// BEHAVIOUR
//   - One clock, one synchronous active-high reset. On reset: ascii = 8'h00.
//   - Latency: ascii updates on the clk rising edge after kb_code, shift and caps_lock are sampled.
//     - Exactly 1 cycle latency.
//     - No handshake; the inputs are re-evaluated every cycle.
//   - Letters A-Z:
//     - Uppercase (0x41-0x5A) when caps_lock XOR shift = 1.
//     - Otherwise lowercase (0x61-0x7A).
//     - Codes: 1C A, 32 B, 21 C, 23 D, 24 E, 2B F, 34 G, 33 H, 43 I, 3B J, 42 K, 4B L, 3A M,
//       31 N, 44 O, 4D P, 15 Q, 2D R, 1B S, 2C T, 3C U, 2A V, 1D W, 22 X, 35 Y, 1A Z.
//   - Digits and punctuation use shift only; caps_lock is ignored. Format is unshifted/shifted:
//     - Digits: 45 0/) 16 1/! 1E 2/@ 26 3/# 25 4/$ 2E 5/% 36 6/^ 3D 7/& 3E 8/* 46 9/(
//     - Punctuation: 0E `/~ 4E -/_ 55 =/+ 54 [/{ 5B ]/} 5D \/| 4C ;/: 52 '/"
//       41 ,/< 49 ./> 4A //?
//   - Control keys ignore both modifiers:
//     - 29 -> 0x20 (space), 5A -> 0x0D (enter), 66 -> 0x08 (backspace).
//     - 0D -> 0x09 (tab), 76 -> 0x1B (esc).
//   - These codes map to UNMAPPED:
//     - Prefix/break codes 0xE0 and 0xF0.
//     - Modifier codes 0x12, 0x59, 0x58, 0x14, 0x11.
//     - Every other code not listed above.
//   - Simultaneous change of kb_code and a modifier: the result is computed from the values sampled in the same cycle.
//   - Reset mid-operation: ascii = 0x00 on the next edge. After reset deasserts, normal translation resumes on the next edge.
//   - No internal state other than the output register. The block does not track caps_lock toggling; the caller owns that.
// STRUCTURE
//   - Shared package kb_pkg: localparams for scan codes and for ASCII constants.
//     - Scan codes: SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_LSHIFT=8'h12, SC_RSHIFT=8'h59, SC_CAPS=8'h58.
//     - ASCII constants: ASCII_CR, ASCII_BS, ASCII_TAB, ASCII_ESC.
//   - One combinational sub-module kb_ascii_lut:
//     - Inputs: kb_code, upper (= caps_lock ^ shift), shift. Output: ascii_next.
//     - Implemented as a full case with default UNMAPPED.
//   - Top level adds only the output register and reset.
// TESTING
//   1. Assert reset with kb_code=1C -> ascii=00. Release reset -> ascii=61 ('a') one cycle later.
//   2. kb_code=1C: shift=1,caps=0 -> 41 ('A'); shift=0,caps=1 -> 41; shift=1,caps=1 -> 61.
//   3. kb_code=16: shift=0 -> 31 ('1'); shift=1 -> 21 ('!'); caps=1,shift=0 -> 31 (caps ignored).
//   4. kb_code=29/5A/66 with every shift and caps_lock combination -> 20/0D/08.
//   5. kb_code=F0, E0, 12, 59 and 00 -> 00 in every case.
//   6. Step kb_code every cycle through 1C, 32, 21 -> ascii 61, 62, 63 on consecutive cycles, each one cycle late.
//      Assert reset during the sequence -> 00 on the next edge.

Source files
------------

// File: rtl/kb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : kb_pkg
// Brief   : Scan-code-set-2 and ASCII constants for the keyboard path.
// Revision: 1.0 - initial release
// ============================================================================
package kb_pkg;

  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_CTRL   = 8'h14;
  localparam logic [7:0] SC_ALT    = 8'h11;

  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_TAB    = 8'h0D;
  localparam logic [7:0] SC_ESC    = 8'h76;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_BS    = 8'h08;
  localparam logic [7:0] ASCII_TAB   = 8'h09;
  localparam logic [7:0] ASCII_ESC   = 8'h1B;

  // Lowercase and uppercase ASCII letters differ only in bit 5.
  localparam logic [7:0] ASCII_CASE_BIT = 8'h20;

endpackage : kb_pkg
`default_nettype wire

// File: rtl/kb_ascii_lut.sv
`default_nettype none
// ============================================================================
// Module  : kb_ascii_lut
// Brief   : Combinational set-2 make code to ASCII lookup with modifiers.
// Revision: 1.0 - initial release
// ============================================================================
module kb_ascii_lut
  import kb_pkg::*;
#(
  parameter logic [7:0] UNMAPPED = 8'h00
) (
  input  logic [7:0] kb_code,
  input  logic       upper,
  input  logic       shift,
  output logic [7:0] ascii_next
);

  logic       w_is_letter;
  logic [7:0] w_lower;

  always_comb begin
    ascii_next  = UNMAPPED;
    w_is_letter = 1'b0;
    w_lower     = 8'h00;
    case (kb_code)
      // Letters: record the lowercase form, case is applied below.
      8'h1C: begin w_is_letter = 1'b1; w_lower = 8'h61; end
      8'h32: begin w_is_letter = 1'b1; w_lower = 8'h62; end
      8'h21: begin w_is_letter = 1'b1; w_lower = 8'h63; end
      8'h23: begin w_is_letter = 1'b1; w_lower = 8'h64; end
      8'h24: begin w_is_letter = 1'b1; w_lower = 8'h65; end
      8'h2B: begin w_is_letter = 1'b1; w_lower = 8'h66; end
      8'h34: begin w_is_letter = 1'b1; w_lower = 8'h67; end
      8'h33: begin w_is_letter = 1'b1; w_lower = 8'h68; end
      8'h43: begin w_is_letter = 1'b1; w_lower = 8'h69; end
      8'h3B: begin w_is_letter = 1'b1; w_lower = 8'h6A; end
      8'h42: begin w_is_letter = 1'b1; w_lower = 8'h6B; end
      8'h4B: begin w_is_letter = 1'b1; w_lower = 8'h6C; end
      8'h3A: begin w_is_letter = 1'b1; w_lower = 8'h6D; end
      8'h31: begin w_is_letter = 1'b1; w_lower = 8'h6E; end
      8'h44: begin w_is_letter = 1'b1; w_lower = 8'h6F; end
      8'h4D: begin w_is_letter = 1'b1; w_lower = 8'h70; end
      8'h15: begin w_is_letter = 1'b1; w_lower = 8'h71; end
      8'h2D: begin w_is_letter = 1'b1; w_lower = 8'h72; end
      8'h1B: begin w_is_letter = 1'b1; w_lower = 8'h73; end
      8'h2C: begin w_is_letter = 1'b1; w_lower = 8'h74; end
      8'h3C: begin w_is_letter = 1'b1; w_lower = 8'h75; end
      8'h2A: begin w_is_letter = 1'b1; w_lower = 8'h76; end
      8'h1D: begin w_is_letter = 1'b1; w_lower = 8'h77; end
      8'h22: begin w_is_letter = 1'b1; w_lower = 8'h78; end
      8'h35: begin w_is_letter = 1'b1; w_lower = 8'h79; end
      8'h1A: begin w_is_letter = 1'b1; w_lower = 8'h7A; end
      // Digits: shift only.
      8'h45: ascii_next = shift ? 8'h29 : 8'h30;
      8'h16: ascii_next = shift ? 8'h21 : 8'h31;
      8'h1E: ascii_next = shift ? 8'h40 : 8'h32;
      8'h26: ascii_next = shift ? 8'h23 : 8'h33;
      8'h25: ascii_next = shift ? 8'h24 : 8'h34;
      8'h2E: ascii_next = shift ? 8'h25 : 8'h35;
      8'h36: ascii_next = shift ? 8'h5E : 8'h36;
      8'h3D: ascii_next = shift ? 8'h26 : 8'h37;
      8'h3E: ascii_next = shift ? 8'h2A : 8'h38;
      8'h46: ascii_next = shift ? 8'h28 : 8'h39;
      // Punctuation: shift only.
      8'h0E: ascii_next = shift ? 8'h7E : 8'h60;
      8'h4E: ascii_next = shift ? 8'h5F : 8'h2D;
      8'h55: ascii_next = shift ? 8'h2B : 8'h3D;
      8'h54: ascii_next = shift ? 8'h7B : 8'h5B;
      8'h5B: ascii_next = shift ? 8'h7D : 8'h5D;
      8'h5D: ascii_next = shift ? 8'h7C : 8'h5C;
      8'h4C: ascii_next = shift ? 8'h3A : 8'h3B;
      8'h52: ascii_next = shift ? 8'h22 : 8'h27;
      8'h41: ascii_next = shift ? 8'h3C : 8'h2C;
      8'h49: ascii_next = shift ? 8'h3E : 8'h2E;
      8'h4A: ascii_next = shift ? 8'h3F : 8'h2F;
      SC_SPACE:  ascii_next = ASCII_SPACE;
      SC_ENTER:  ascii_next = ASCII_CR;
      SC_BKSP:   ascii_next = ASCII_BS;
      SC_TAB:    ascii_next = ASCII_TAB;
      SC_ESC:    ascii_next = ASCII_ESC;
      SC_BREAK, SC_EXT, SC_LSHIFT, SC_RSHIFT, SC_CAPS, SC_CTRL, SC_ALT:
        ascii_next = UNMAPPED;
      default:   ascii_next = UNMAPPED;
    endcase
    if (w_is_letter) begin
      ascii_next = upper ? (w_lower & ~ASCII_CASE_BIT) : w_lower;
    end
  end

endmodule : kb_ascii_lut
`default_nettype wire

// File: rtl/kb_code_ascii_converter.sv
`default_nettype none
// ============================================================================
// Module  : kb_code_ascii_converter
// Brief   : Registered PS/2 set-2 make code to ASCII translator.
// Revision: 1.0 - initial release
// ============================================================================
module kb_code_ascii_converter
  import kb_pkg::*;
#(
  parameter logic [7:0] UNMAPPED = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] kb_code,
  input  logic       caps_lock,
  input  logic       shift,
  output logic [7:0] ascii
);

  logic [7:0] w_ascii_next;
  logic [7:0] r_ascii;

  kb_ascii_lut #(
    .UNMAPPED   (UNMAPPED)
  ) u_lut (
    .kb_code    (kb_code),
    .upper      (caps_lock ^ shift),
    .shift      (shift),
    .ascii_next (w_ascii_next)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ascii <= 8'h00;
    end else begin
      r_ascii <= w_ascii_next;
    end
  end

  assign ascii = r_ascii;

endmodule : kb_code_ascii_converter
`default_nettype wire

// File: tb/tb_kb_code_ascii_converter.sv
`default_nettype none
// ============================================================================
// Module  : tb_kb_code_ascii_converter
// Brief   : Directed self-checking bench for kb_code_ascii_converter.
// Revision: 1.0 - initial release
// ============================================================================
module tb_kb_code_ascii_converter;

  logic       clk;
  logic       reset;
  logic [7:0] kb_code;
  logic       caps_lock;
  logic       shift;
  logic [7:0] ascii;

  int n_checks = 0;
  int n_errors = 0;

  kb_code_ascii_converter #(
    .UNMAPPED  (8'h00)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .kb_code   (kb_code),
    .caps_lock (caps_lock),
    .shift     (shift),
    .ascii     (ascii)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; the result is sampled one falling edge later.
  task automatic drive(input logic [7:0] code, input logic sh, input logic cl);
    @(negedge clk);
    kb_code   = code;
    shift     = sh;
    caps_lock = cl;
  endtask

  task automatic test_reset();
    reset = 1'b1; kb_code = 8'h1C; shift = 1'b0; caps_lock = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (ascii !== 8'h00) begin
      $display("FAIL reset_state: got %h want 00", ascii); n_errors++;
    end
    reset = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ascii !== 8'h61) begin
      $display("FAIL reset_release: got %h want 61", ascii); n_errors++;
    end
  endtask

  task automatic test_letters();
    logic [9:0] vec [3] = '{ {1'b1, 1'b0, 8'h41}, {1'b0, 1'b1, 8'h41}, {1'b1, 1'b1, 8'h61} };
    for (int i = 0; i < 3; i++) begin
      drive(8'h1C, vec[i][9], vec[i][8]);
      @(negedge clk);
      n_checks++;
      if (ascii !== vec[i][7:0]) begin
        $display("FAIL letter_case[%0d] sh=%b cl=%b: got %h want %h",
                 i, vec[i][9], vec[i][8], ascii, vec[i][7:0]);
        n_errors++;
      end
    end
  endtask

  task automatic test_digits();
    logic [9:0] vec [3] = '{ {1'b0, 1'b0, 8'h31}, {1'b1, 1'b0, 8'h21}, {1'b0, 1'b1, 8'h31} };
    for (int i = 0; i < 3; i++) begin
      drive(8'h16, vec[i][9], vec[i][8]);
      @(negedge clk);
      n_checks++;
      if (ascii !== vec[i][7:0]) begin
        $display("FAIL digit_1[%0d] sh=%b cl=%b: got %h want %h",
                 i, vec[i][9], vec[i][8], ascii, vec[i][7:0]);
        n_errors++;
      end
    end
  endtask

  task automatic test_punct();
    logic [23:0] vec [4] = '{ {8'h52, 8'h27, 8'h22}, {8'h4A, 8'h2F, 8'h3F},
                              {8'h5D, 8'h5C, 8'h7C}, {8'h1E, 8'h32, 8'h40} };
    for (int i = 0; i < 4; i++) begin
      for (int s = 0; s < 2; s++) begin
        drive(vec[i][23:16], s[0], 1'b1);
        @(negedge clk);
        n_checks++;
        if (ascii !== (s[0] ? vec[i][7:0] : vec[i][15:8])) begin
          $display("FAIL punct code=%h sh=%0d: got %h want %h", vec[i][23:16], s, ascii,
                   s[0] ? vec[i][7:0] : vec[i][15:8]);
          n_errors++;
        end
      end
    end
  endtask

  task automatic test_control();
    logic [15:0] vec [5] = '{ {8'h29, 8'h20}, {8'h5A, 8'h0D}, {8'h66, 8'h08},
                              {8'h0D, 8'h09}, {8'h76, 8'h1B} };
    for (int i = 0; i < 5; i++) begin
      for (int m = 0; m < 4; m++) begin
        drive(vec[i][15:8], m[0], m[1]);
        @(negedge clk);
        n_checks++;
        if (ascii !== vec[i][7:0]) begin
          $display("FAIL control code=%h sh=%b cl=%b: got %h want %h",
                   vec[i][15:8], m[0], m[1], ascii, vec[i][7:0]);
          n_errors++;
        end
      end
    end
  endtask

  task automatic test_unmapped();
    logic [7:0] codes [8] = '{ 8'hF0, 8'hE0, 8'h12, 8'h59, 8'h00, 8'h58, 8'h14, 8'hFF };
    for (int i = 0; i < 8; i++) begin
      for (int m = 0; m < 4; m++) begin
        drive(codes[i], m[0], m[1]);
        @(negedge clk);
        n_checks++;
        if (ascii !== 8'h00) begin
          $display("FAIL unmapped code=%h sh=%b cl=%b: got %h want 00",
                   codes[i], m[0], m[1], ascii);
          n_errors++;
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] codes [3] = '{ 8'h1C, 8'h32, 8'h21 };
    logic [7:0] exp   [3] = '{ 8'h61, 8'h62, 8'h63 };
    drive(8'h00, 1'b0, 1'b0);
    drive(codes[0], 1'b0, 1'b0);
    #1;
    n_checks++;
    if (ascii !== 8'h00) begin
      $display("FAIL b2b_latency: got %h want 00 before edge", ascii); n_errors++;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (ascii !== exp[i]) begin
        $display("FAIL b2b_step[%0d]: got %h want %h", i, ascii, exp[i]); n_errors++;
      end
      if (i < 2) kb_code = codes[i+1];
    end
    // Simultaneous code and modifier change, then reset mid-stream.
    kb_code = 8'h32; shift = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ascii !== 8'h42) begin
      $display("FAIL b2b_simul: got %h want 42", ascii); n_errors++;
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (ascii !== 8'h00) begin
      $display("FAIL b2b_reset: got %h want 00", ascii); n_errors++;
    end
    reset = 1'b0; kb_code = 8'h21; shift = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ascii !== 8'h63) begin
      $display("FAIL b2b_resume: got %h want 63", ascii); n_errors++;
    end
  endtask

  initial begin
    test_reset();
    test_letters();
    test_digits();
    test_punct();
    test_control();
    test_unmapped();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_kb_code_ascii_converter
`default_nettype wire
